// File: rtl/micro_pkg.sv
// micro_pkg: shared definitions for the 12-bit accumulator micro datapath.
//   - instruction / data widths
//   - opcode constants the datapath has to recognise (gating, halt, reserved)
//   - SelAcc and SelALU field encodings
//   - sequencer state enum and the ALU response struct
package micro_pkg;

    localparam int INSTR_W = 12;
    localparam int DATA_W  = 8;

    // Opcodes the datapath itself reacts to; all others just apply strobes.
    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_BRZ_A = 4'b0110;  // needs Z=1
    localparam logic [3:0] OP_BRZ_B = 4'b0111;  // needs Z=1
    localparam logic [3:0] OP_BRC_A = 4'b1000;  // needs C=1
    localparam logic [3:0] OP_RSV_A = 4'b1001;  // reserved
    localparam logic [3:0] OP_BRC_B = 4'b1010;  // needs C=1
    localparam logic [3:0] OP_RSV_B = 4'b1110;  // reserved
    localparam logic [3:0] OP_HALT  = 4'b1111;

    typedef enum logic [1:0] {
        ACC_ALU  = 2'b00,
        ACC_REG  = 2'b01,
        ACC_IMM  = 2'b10,
        ACC_HOLD = 2'b11
    } accSel_e;

    // SelALU[3:2]
    typedef enum logic [1:0] {
        ALU_PASS = 2'b00,
        ALU_NOR  = 2'b01,
        ALU_ADD  = 2'b10,
        ALU_SUB  = 2'b11
    } aluOp_e;

    // SelALU[1:0]; 2'b10 is a second "no shift" code
    typedef enum logic [1:0] {
        SH_NONE  = 2'b00,
        SH_LEFT  = 2'b01,
        SH_NONE2 = 2'b10,
        SH_RIGHT = 2'b11
    } shift_e;

    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        DECODE  = 2'b01,
        EXECUTE = 2'b10,
        HALTED  = 2'b11
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              carry;
        logic              zero;
    } aluRsp_t;

endpackage

// File: rtl/micro_alu.sv
// micro_alu: purely combinational ALU. Op first, then optional 1-bit shift.
// Ports:
//   a, b    in  DATA_W : operands (a = accumulator, b = register file read)
//   selAlu  in  4      : [3:2] op (pass/NOR/ADD/SUB), [1:0] shift
//   rsp     out        : result, carry, zero
module micro_alu
    import micro_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        selAlu,
    output aluRsp_t           rsp
);

    logic [DATA_W:0]   opRes;   // MSB is the op's carry out
    logic [DATA_W-1:0] shRes;
    logic              shCarry;

    always_comb begin
        opRes = {1'b0, a};
        case (selAlu[3:2])
            ALU_ADD: opRes = {1'b0, a} + {1'b0, b};
            // carry out of A+~B+1 is the "no borrow" flag
            ALU_SUB: opRes = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
            ALU_NOR: opRes = {1'b0, ~(a | b)};
            default: opRes = {1'b0, a};
        endcase

        shRes   = opRes[DATA_W-1:0];
        shCarry = opRes[DATA_W];
        case (selAlu[1:0])
            SH_LEFT: begin
                shRes   = {opRes[DATA_W-2:0], 1'b0};
                shCarry = opRes[DATA_W-1];
            end
            SH_RIGHT: begin
                shRes   = {1'b0, opRes[DATA_W-1:1]};
                shCarry = opRes[0];
            end
            default: ;
        endcase

        rsp.result = shRes;
        rsp.carry  = shCarry;
        rsp.zero   = (shRes == '0);
    end

endmodule

// File: rtl/micro_datapath.sv
// micro_datapath: PC/IR/accumulator/register file/flags plus the
// FETCH -> DECODE -> EXECUTE sequencer of the 12-bit accumulator micro.
// Controller strobes are sampled only on the EXECUTE edge.
// Ports:
//   clk, CLB (async active-high reset)
//   IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc[1:0], SelALU[3:0] : strobes
//   Opcode[3:0], Z, C, LoadIR            : back to the controller
//   imem_req, imem_addr / imem_valid, imem_data : instruction fetch
//   halted, illegal, acc                 : status / debug
// Build option: MICRO_ILLEGAL_TRAP_EN makes opcodes 1001/1110 halt with
// illegal=1 instead of executing as NOPs.
module micro_datapath
    import micro_pkg::*;
#(
    parameter int PC_W = 8,
    parameter int NREG = 4
) (
    input  logic               clk,
    input  logic               CLB,
    input  logic               IncPC,
    input  logic               SelPC,
    input  logic               LoadPC,
    input  logic               LoadReg,
    input  logic               LoadAcc,
    input  logic [1:0]         SelAcc,
    input  logic [3:0]         SelALU,
    output logic [3:0]         Opcode,
    output logic               Z,
    output logic               C,
    output logic               LoadIR,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               halted,
    output logic               illegal,
    output logic [DATA_W-1:0]  acc
);

    localparam int REG_AW = $clog2(NREG);

    state_e                      state, stateNxt;
    logic [PC_W-1:0]             pc, pcNxt;
    logic [INSTR_W-1:0]          ir;
    logic [DATA_W-1:0]           accNxt;
    logic [NREG-1:0][DATA_W-1:0] regs;
    logic [REG_AW-1:0]           idx;
    logic [DATA_W-1:0]           regRd;
    aluRsp_t                     aluRsp;
    logic                        skip, trap, exec, commit, flagLd;

    assign idx       = ir[REG_AW-1:0];
    assign regRd     = regs[idx];
    assign Opcode    = ir[INSTR_W-1:INSTR_W-4];
    assign imem_req  = (state == FETCH) && !CLB;
    assign LoadIR    = imem_req && imem_valid;
    assign imem_addr = pc;
    assign halted    = (state == HALTED);

    micro_alu uAlu (
        .a      (acc),
        .b      (regRd),
        .selAlu (SelALU),
        .rsp    (aluRsp)
    );

    // Untaken conditionals and NOP-class opcodes ignore the (stale) strobes.
    always_comb begin
        skip = 1'b0;
        case (Opcode)
            OP_NOP, OP_RSV_A, OP_RSV_B: skip = 1'b1;
            OP_BRZ_A, OP_BRZ_B:         skip = !Z;
            OP_BRC_A, OP_BRC_B:         skip = !C;
            default:                    skip = 1'b0;
        endcase
    end

`ifdef MICRO_ILLEGAL_TRAP_EN
    assign trap = (Opcode == OP_RSV_A) || (Opcode == OP_RSV_B);
`else
    assign trap = 1'b0;
`endif

    // exec: an EXECUTE cycle that retires normally (not halt/trap)
    assign exec   = (state == EXECUTE) && (Opcode != OP_HALT) && !trap;
    assign commit = exec && !skip;
    assign flagLd = commit && LoadAcc && (SelAcc == ACC_ALU);

    always_comb begin
        stateNxt = state;
        case (state)
            FETCH:   if (imem_valid) stateNxt = DECODE;
            DECODE:  stateNxt = EXECUTE;
            EXECUTE: stateNxt = ((Opcode == OP_HALT) || trap) ? HALTED : FETCH;
            default: stateNxt = HALTED;
        endcase
    end

    always_comb begin
        pcNxt = pc;
        if (commit) begin
            if (LoadPC)     pcNxt = SelPC ? regRd[PC_W-1:0] : ir[PC_W-1:0];
            else if (IncPC) pcNxt = pc + PC_W'(1);
        end else if (exec) begin
            pcNxt = pc + PC_W'(1);
        end
    end

    always_comb begin
        accNxt = acc;
        if (commit && LoadAcc) begin
            case (SelAcc)
                ACC_ALU: accNxt = aluRsp.result;
                ACC_REG: accNxt = regRd;
                ACC_IMM: accNxt = ir[DATA_W-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge CLB) begin
        if (CLB) begin
            state <= FETCH;
            pc    <= '0;
            ir    <= '0;
            acc   <= '0;
            regs  <= '0;
            Z     <= 1'b0;
            C     <= 1'b0;
        end else begin
            state <= stateNxt;
            pc    <= pcNxt;
            acc   <= accNxt;
            if (LoadIR)            ir        <= imem_data;
            // register write takes the accumulator value before this edge
            if (commit && LoadReg) regs[idx] <= acc;
            if (flagLd) begin
                Z <= aluRsp.zero;
                C <= aluRsp.carry;
            end
        end
    end

`ifdef MICRO_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or posedge CLB) begin
        if (CLB)                            illegal <= 1'b0;
        else if ((state == EXECUTE) && trap) illegal <= 1'b1;
    end
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: doc/micro_datapath.md
# micro_datapath

Datapath and fetch/execute sequencer for the 12-bit accumulator micro. It is the responder to the controller FSM's control strobes: it owns PC, IR, accumulator, register file, ALU and Z/C flags. It presents `Opcode`, `Z` and `C` back to the controller and applies the controller's registered strobes once per instruction. It also fetches instructions from instruction memory over a req/valid handshake.

## Interface
- `PC_W`, 8: program counter width, ≤ 8. Jump targets are `IR[PC_W-1:0]`.
- `NREG`, 4: register-file depth, power of 2. Index `REG_AW = log2(NREG)` is taken from `IR[REG_AW-1:0]`.
- `clk`  in  1: clock, all state on rising edge.
- `CLB`  in  1: reset, asynchronous, active-high.
- `IncPC`, `SelPC`, `LoadPC`, `LoadReg`, `LoadAcc`  in  1 each: controller strobes.
- `SelAcc`  in  2: accumulator source select.
- `SelALU`  in  4: bits [3:2] select the ALU op, bits [1:0] select the shift.
- `Opcode`  out  4: `IR[11:8]`.
- `Z`, `C`  out  1 each: flags.
- `LoadIR`  out  1: one-cycle pulse when IR loads.
- `imem_req`  out  1, `imem_addr`  out  PC_W: fetch request.
- `imem_valid`  in  1, `imem_data`  in  12: fetch response.
- `halted`  out  1, `illegal`  out  1, `acc`  out  8: status and debug.

## Operation
- States are FETCH, DECODE, EXECUTE and HALTED. Reset state is FETCH.
- FETCH:
  - `imem_req=1`, `imem_addr=PC`.
  - When `imem_valid` is high (the same cycle is allowed): IR ← `imem_data`, `LoadIR` pulses, go to DECODE.
- DECODE: one cycle with no state change, so the controller can register its strobes. Then go to EXECUTE.
- EXECUTE: apply the strobes once, then go to FETCH. Exception: opcode `1111` goes to HALTED.
- Strobe gating in EXECUTE: all strobes are ignored and PC ← PC+1 for:
  - opcodes `0000`, `1001`, `1110`;
  - opcode `0110` or `0111` with Z=0;
  - opcode `1000` or `1010` with C=0.

  The controller holds stale strobes in these cases.
- PC update: `LoadPC` has priority. `SelPC=1` loads reg[rs]; `SelPC=0` loads the immediate. Otherwise `IncPC` gives PC+1. Otherwise PC holds. PC wraps modulo 2^PC_W.
- Accumulator source (on `LoadAcc`) is chosen by `SelAcc`:
  - `00`: ALU result;
  - `01`: reg[rs];
  - `10`: `IR[7:0]`;
  - `11`: hold.
- `LoadReg`: reg[rd] ← acc. This uses the pre-update accumulator if `LoadAcc` is also high.
- ALU operates on A=acc, B=reg[idx]. Ops by `SelALU[3:2]`:
  - `10` ADD: C = carry out.
  - `11` SUB: A+~B+1, C = carry out (1 = no borrow).
  - `01` NOR: C=0.
  - `00` pass A.
- Shift, applied after the op, by `SelALU[1:0]`:
  - `01` SHL: C = old bit 7.
  - `11` SHR: C = old bit 0.
  - `00`/`10` none.
- Flags update only on `LoadAcc & SelAcc==00`. Z = (result==0). Results are 8-bit and truncate.
- HALTED: `imem_req=0`, `halted=1`. Exit only by reset.

## Timing
- Minimum 3 cycles per instruction. Each FETCH wait cycle adds 1.
- While `imem_valid` is low, `imem_req` and `imem_addr` stay stable. `LoadIR` is exactly one cycle per accepted fetch.
- Z/C change only at the EXECUTE edge, so they are stable for the controller through FETCH and DECODE.
- Reset values:
  - PC=0, IR=0 (so `Opcode`=0), acc=0, all regs=0, Z=C=0;
  - `LoadIR`=0, `halted`=0, `illegal`=0;
  - `imem_req`=0 while `CLB` is high, asserted in the first cycle after release.
- Reset mid-instruction aborts it with no partial commit.

## Configuration
- `MICRO_ILLEGAL_TRAP_EN` defined: opcodes `1001` and `1110` in EXECUTE go to HALTED with `illegal=1` and PC unchanged.
- Undefined: they execute as NOPs (PC+1) and `illegal` is tied 0.

## Structure
- `micro_pkg` holds:
  - opcode constants;
  - `SelAcc` and `SelALU` encodings;
  - the state enum;
  - `INSTR_W=12` and `DATA_W=8`.
- Sub-module `micro_alu` is purely combinational: op, shift, result, carry, zero.

## Test plan
- Reset while in EXECUTE → PC=0x00, acc=0x00, Z=C=0, `Opcode`=0, `halted`=0, next cycle `imem_req=1`, `imem_addr`=0x00.
- r1=0x20, `0xDF0` (acc=0xF0) then ADD r1 → acc=0x10, C=1, Z=0, PC advanced by 2.
- acc=0x20, r1=0x20, SUB → acc=0x00, Z=1, C=1. Then `0x740` → next `imem_addr`=0x40.
- C=0 with stale `LoadPC=1` from the previous jump, then `0xA55` → not taken, PC=PC+1.
- acc=0x01, SHR → acc=0x00, Z=1, C=1. `imem_valid` delayed 3 cycles → req/addr held, single `LoadIR` pulse.
- `0x900`: with the macro → `halted=1`, `illegal=1`, `imem_req=0`; without it → PC+1. `0xF00` → `halted=1`, PC frozen.
